// File: rtl/sram_axi_bridge_n.sv
// sram_axi_bridge_n: NCH like-SRAM channels to one AXI master port.
// Round-robin grant, one AXI transaction in flight at a time.
// Optional macro BRIDGE_WRAP_EN: cached reads are issued as WRAP bursts
// starting at the requested word (critical word first).
module sram_axi_bridge_n #(
    parameter int NCH        = 2,
    parameter int LINE_WORDS = 8
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst,
    input  logic [4*NCH-1:0]    ch_ben,
    input  logic [NCH-1:0]      ch_wr,
    input  logic [NCH-1:0]      ch_uncached,
    input  logic [32*NCH-1:0]   ch_addr,
    input  logic [32*NCH-1:0]   ch_wdata,
    output logic [NCH-1:0]      ch_addr_ok,
    output logic [NCH-1:0]      ch_beat_ok,
    output logic [NCH-1:0]      ch_data_ok,
    output logic [31:0]         ch_rdata,
    output logic [NCH-1:0]      ch_err,
    output logic [3:0]          awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [3:0]          wid,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [3:0]          arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [3:0]          rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d, rr_q, rr_d, pick;
    logic [3:0]      ben_q, ben_d;
    logic            wr_q, wr_d, unc_q, unc_d, err_q, err_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      cnt_q, cnt_d, len_c;
    logic            req_any, done, err_now;
    logic [2:0]      usize;
    logic [1:0]      uoff;
    logic [31:0]     uaddr, laddr;
    int              idx;
    logic            unused_ok;

    assign unused_ok = ^{bid, rid};

    // Round-robin pick: scan downwards so the lowest offset from rr_q wins.
    always_comb begin
        req_any = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % NCH;
            if (ch_ben[idx*4 +: 4] != 4'b0000) begin
                req_any = 1'b1;
                pick    = GW'(idx);
            end
        end
    end

    // Uncached size/byte-offset from the latched byte enables.
    always_comb begin
        usize = 3'd2;
        uoff  = 2'b00;
        case (ben_q)
            4'b0011: begin usize = 3'd1; uoff = 2'b00; end
            4'b1100: begin usize = 3'd1; uoff = 2'b10; end
            4'b0001: begin usize = 3'd0; uoff = 2'b00; end
            4'b0010: begin usize = 3'd0; uoff = 2'b01; end
            4'b0100: begin usize = 3'd0; uoff = 2'b10; end
            4'b1000: begin usize = 3'd0; uoff = 2'b11; end
            default: begin usize = 3'd2; uoff = 2'b00; end
        endcase
    end

    assign uaddr = {addr_q[31:2], uoff};
    assign laddr = addr_q & ~LINE_MASK;
    assign len_c = unc_q ? 8'd0 : 8'(LINE_WORDS - 1);

    assign awid    = 4'(gnt_q);
    assign wid     = 4'(gnt_q);
    assign arid    = 4'(gnt_q);
    assign awaddr  = unc_q ? uaddr : laddr;
    assign awlen   = len_c;
    assign awsize  = unc_q ? usize : 3'd2;
    assign awburst = 2'b01;
    assign arlen   = len_c;
    assign arsize  = unc_q ? usize : 3'd2;
`ifdef BRIDGE_WRAP_EN
    assign araddr  = unc_q ? uaddr : {addr_q[31:2], 2'b00};
    assign arburst = unc_q ? 2'b01 : 2'b10;
`else
    assign araddr  = unc_q ? uaddr : laddr;
    assign arburst = 2'b01;
`endif
    assign awlock  = 1'b0;
    assign arlock  = 1'b0;
    assign awcache = 4'd0;
    assign arcache = 4'd0;
    assign awprot  = 3'd0;
    assign arprot  = 3'd0;

    assign arvalid  = (state_q == AR);
    assign rready   = (state_q == R);
    assign awvalid  = (state_q == AW);
    assign wvalid   = (state_q == W);
    assign bready   = (state_q == B);
    assign wlast    = (state_q == W) && (cnt_q == len_c);
    assign wdata    = ch_wdata[gnt_q*32 +: 32];
    assign wstrb    = unc_q ? ben_q : 4'hf;
    assign ch_rdata = rdata;

    // Next-state logic and per-channel handshake pulses.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        ben_d      = ben_q;
        wr_d       = wr_q;
        unc_d      = unc_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_now    = err_q;
        done       = 1'b0;
        ch_addr_ok = '0;
        ch_beat_ok = '0;
        ch_data_ok = '0;
        ch_err     = '0;
        case (state_q)
            IDLE: if (req_any && !cpu_rst) begin
                ch_addr_ok[pick] = 1'b1;
                gnt_d   = pick;
                ben_d   = ch_ben[pick*4 +: 4];
                wr_d    = ch_wr[pick];
                unc_d   = ch_uncached[pick];
                addr_d  = ch_addr[pick*32 +: 32];
                cnt_d   = 8'd0;
                err_d   = 1'b0;
                state_d = ch_wr[pick] ? AW : AR;
            end
            AR: if (arready) state_d = R;
            R: if (rvalid) begin
                ch_beat_ok[gnt_q] = 1'b1;
                err_now = err_q | (rresp != 2'b00);
                err_d   = err_now;
                if (rlast) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            AW: if (awready) state_d = W;
            W: if (wready) begin
                ch_beat_ok[gnt_q] = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == len_c) state_d = B;
            end
            B: if (bvalid) begin
                err_now = err_q | (bresp != 2'b00);
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            ch_data_ok[gnt_q] = 1'b1;
            ch_err[gnt_q]     = err_now;
            err_d             = 1'b0;
            rr_d = (int'(gnt_q) == NCH - 1) ? '0 : gnt_q + GW'(1);
        end
    end

    // State and latched request registers.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            ben_q   <= 4'd0;
            wr_q    <= 1'b0;
            unc_q   <= 1'b0;
            addr_q  <= 32'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            ben_q   <= ben_d;
            wr_q    <= wr_d;
            unc_q   <= unc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_sram_axi_bridge_n.sv
// Bench for sram_axi_bridge_n: channel + AXI slave models, per-cycle checks
// against transaction expectations computed from the address/size rules.
module tb_sram_axi_bridge_n;
    localparam int NCH = 2;
    localparam int LW  = 8;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [4*NCH-1:0]  ch_ben = '0;
    logic [NCH-1:0]    ch_wr = '0, ch_uncached = '0;
    logic [32*NCH-1:0] ch_addr = '0, ch_wdata = '0;
    logic [NCH-1:0]    ch_addr_ok, ch_beat_ok, ch_data_ok, ch_err;
    logic [31:0]       ch_rdata;
    logic [3:0]  awid, wid, arid, awcache, arcache;
    logic [31:0] awaddr, araddr, wdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst;
    logic        awlock, arlock, awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [3:0]  wstrb;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
    logic [3:0]  bid = 0, rid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;

    sram_axi_bridge_n #(.NCH(NCH), .LINE_WORDS(LW)) dut (
        .cpu_clk_50M(clk), .cpu_rst(rst),
        .ch_ben(ch_ben), .ch_wr(ch_wr), .ch_uncached(ch_uncached), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok), .ch_beat_ok(ch_beat_ok),
        .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata), .ch_err(ch_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int total = 0, bad = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // channel models
    logic [3:0]  m_ben[NCH];
    logic [31:0] m_addr[NCH], m_wbase[NCH];
    bit          m_wr[NCH], m_unc[NCH], m_act[NCH], m_auto[NCH], m_err[NCH];
    int          m_beats[NCH];
    int          cur = -1, ptr = 0;
    // expected AXI fields of the current transaction
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic [1:0]  e_burst;
    int          e_len;
    // slave model
    bit          rnd = 0, rd_act = 0, w_act = 0, b_pend = 0;
    logic [31:0] s_addr;
    logic [1:0]  s_burst, b_resp;
    int          s_len, s_beat, w_beat, err_beat = -1, force_err = -1;
    // captures
    logic [31:0] cap_addr;
    logic [2:0]  cap_size;
    logic [7:0]  cap_len;
    logic [1:0]  cap_burst;
    logic [3:0]  cap_strb;
    bit          cap_err;
    int          cap_beats, nb_ok, n_aw = 0;
    int          glog[$];

    function automatic logic [31:0] mem(logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        return {w[15:0], ~w[31:16]} ^ 32'h5a3c_96e1;
    endfunction

    // address of beat i as a channel expects it
    function automatic logic [31:0] ebeat_addr(int c, int i);
        logic [31:0] a, line;
        int woff;
        a = m_addr[c];
        if (m_unc[c]) return a & ~32'd3;
        line = a - (a % (LW * 4));
        woff = 0;
`ifdef BRIDGE_WRAP_EN
        woff = (a % (LW * 4)) / 4;
`endif
        return line + 32'(4 * ((woff + i) % LW));
    endfunction

    // address of the slave's current read beat, from the AR it accepted
    function automatic logic [31:0] s_baddr();
        int bytes;
        logic [31:0] base;
        bytes = (s_len + 1) * 4;
        if (s_burst == 2'b10) begin
            base = s_addr - (s_addr % bytes);
            return base + ((s_addr - base + 32'(4 * s_beat)) % bytes);
        end
        return (s_addr & ~32'd3) + 32'(4 * s_beat);
    endfunction

    task automatic set_exp(int c);
        logic [31:0] a;
        int n, bi;
        a = m_addr[c];
        n = $countones(m_ben[c]);
        bi = 0;
        for (int b = 0; b < 4; b++) if (m_ben[c][b]) bi = b;
        e_burst = 2'b01;
        if (m_unc[c]) begin
            e_len = 0;
            if (n == 1) begin e_size = 3'd0; e_addr = (a & ~32'd3) + 32'(bi); end
            else if (n == 2) begin e_size = 3'd1; e_addr = (a & ~32'd3) + ((m_ben[c] == 4'hc) ? 32'd2 : 32'd0); end
            else begin e_size = 3'd2; e_addr = a & ~32'd3; end
        end else begin
            e_len = LW - 1;
            e_size = 3'd2;
            e_addr = a - (a % (LW * 4));
`ifdef BRIDGE_WRAP_EN
            if (!m_wr[c]) begin e_addr = a & ~32'd3; e_burst = 2'b10; end
`endif
        end
    endtask

    task automatic req(int c, bit wr, bit unc, logic [3:0] ben, logic [31:0] addr);
        m_wr[c] = wr; m_unc[c] = unc; m_ben[c] = ben; m_addr[c] = addr;
        m_wbase[c] = $urandom; m_act[c] = 1;
    endtask

    task automatic clr_model();
        cur = -1; ptr = 0; rd_act = 0; w_act = 0; b_pend = 0;
        for (int c = 0; c < NCH; c++) begin m_act[c] = 0; m_auto[c] = 0; end
    endtask

    task automatic step();
        logic [NCH-1:0] eaok, ebok, edok, eerr;
        bit rbeat, wbeat, bdone;
        int g;
        @(negedge clk);
        arready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        awready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        wready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        rvalid  = rd_act && (!rnd || $urandom_range(0, 3) != 0);
        rdata   = mem(s_baddr());
        rresp   = (s_beat == err_beat) ? 2'b10 : 2'b00;
        rlast   = (s_beat == s_len);
        bvalid  = b_pend && (!rnd || $urandom_range(0, 1) == 1);
        bresp   = b_resp;
        for (int c = 0; c < NCH; c++) begin
            ch_ben[c*4 +: 4]    = m_act[c] ? m_ben[c] : 4'h0;
            ch_wr[c]            = m_wr[c];
            ch_uncached[c]      = m_unc[c];
            ch_addr[c*32 +: 32] = m_addr[c];
            ch_wdata[c*32 +: 32] = m_wbase[c] + 32'(m_beats[c]);
        end
        #1;
        eaok = '0; ebok = '0; edok = '0; eerr = '0; g = -1;
        if (cur < 0)
            for (int i = 0; i < NCH; i++)
                if (g < 0 && m_act[(ptr + i) % NCH]) g = (ptr + i) % NCH;
        if (g >= 0) eaok[g] = 1'b1;
        chk("addr_ok", ch_addr_ok, eaok);
        chk("rready", rready, rd_act);
        chk("wvalid", wvalid, w_act);
        chk("bready", bready, b_pend);
        rbeat = rd_act && rvalid;
        wbeat = w_act && wready;
        bdone = b_pend && bvalid;
        if (cur >= 0 && (rbeat || wbeat)) ebok[cur] = 1'b1;
        if (cur >= 0 && ((rbeat && rlast) || bdone)) edok[cur] = 1'b1;
        if (rbeat) begin
            chk("rdata", ch_rdata, mem(ebeat_addr(cur, m_beats[cur])));
            m_err[cur] |= (rresp != 2'b00);
            m_beats[cur]++; s_beat++;
            if (rlast) rd_act = 0;
        end
        if (wbeat) begin
            chk("wdata", wdata, m_wbase[cur] + 32'(w_beat));
            chk("wstrb", wstrb, m_unc[cur] ? m_ben[cur] : 4'hf);
            chk("wlast", wlast, w_beat == e_len);
            cap_strb = wstrb;
            if (w_beat == e_len) begin
                w_act = 0; b_pend = 1;
                b_resp = (rnd && $urandom_range(0, 4) == 0) ? 2'b11 : 2'b00;
            end
            m_beats[cur]++; w_beat++;
        end
        if (bdone) begin m_err[cur] |= (bresp != 2'b00); b_pend = 0; end
        if (cur >= 0 && edok[cur]) eerr[cur] = m_err[cur];
        chk("beat_ok", ch_beat_ok, ebok);
        chk("data_ok", ch_data_ok, edok);
        chk("err", ch_err, eerr);
        if (ch_beat_ok != '0) nb_ok++;
        if (edok != '0) begin
            cap_err = m_err[cur]; cap_beats = nb_ok;
            ptr = (cur + 1) % NCH;
            if (m_auto[cur]) m_act[cur] = 1;
            cur = -1;
        end
        if (arvalid && arready) begin
            chk("araddr", araddr, e_addr); chk("arlen", arlen, e_len);
            chk("arsize", arsize, e_size); chk("arburst", arburst, e_burst);
            chk("arid", arid, cur);
            cap_addr = araddr; cap_size = arsize; cap_len = arlen; cap_burst = arburst;
            rd_act = 1; s_addr = araddr; s_len = int'(arlen); s_burst = arburst; s_beat = 0;
            if (force_err >= 0) err_beat = force_err;
            else if (rnd && $urandom_range(0, 3) == 0) err_beat = $urandom_range(0, s_len);
            else err_beat = -1;
        end
        if (awvalid && awready) begin
            chk("awaddr", awaddr, e_addr); chk("awlen", awlen, e_len);
            chk("awsize", awsize, e_size); chk("awburst", awburst, 2'b01);
            chk("awid", awid, cur);
            cap_addr = awaddr; cap_size = awsize; cap_len = awlen; cap_burst = awburst;
            w_act = 1; w_beat = 0; n_aw++;
        end
        if (g >= 0) begin
            cur = g; m_act[g] = 0; m_beats[g] = 0; m_err[g] = 0; nb_ok = 0;
            set_exp(g); glog.push_back(g);
        end
    endtask

    function automatic bit any_act();
        for (int c = 0; c < NCH; c++) if (m_act[c]) return 1;
        return 0;
    endfunction

    task automatic drain(int max);
        int n;
        n = 0;
        while ((cur >= 0 || any_act()) && n < max) begin step(); n++; end
        chk("drain_timeout", n < max, 1);
    endtask

    typedef struct {
        logic [3:0] ben; logic wr; logic [31:0] addr;
        logic [31:0] eaddr; logic [2:0] esize; logic [3:0] estrb;
    } vec_t;
    vec_t tbl[7];
    logic [3:0] blist[7];

    initial begin
        tbl[0] = '{4'hf, 1'b0, 32'h1fc0_0004, 32'h1fc0_0004, 3'd2, 4'hf};
        tbl[1] = '{4'h4, 1'b1, 32'h0000_0100, 32'h0000_0102, 3'd0, 4'h4};
        tbl[2] = '{4'h3, 1'b0, 32'h0000_0203, 32'h0000_0200, 3'd1, 4'h3};
        tbl[3] = '{4'hc, 1'b1, 32'h0000_0204, 32'h0000_0206, 3'd1, 4'hc};
        tbl[4] = '{4'h1, 1'b0, 32'h0000_0033, 32'h0000_0030, 3'd0, 4'h1};
        tbl[5] = '{4'h8, 1'b1, 32'h0000_0040, 32'h0000_0043, 3'd0, 4'h8};
        tbl[6] = '{4'h2, 1'b0, 32'h0000_0051, 32'h0000_0051, 3'd0, 4'h2};
        blist = '{4'hf, 4'h3, 4'hc, 4'h1, 4'h2, 4'h4, 4'h8};
        for (int c = 0; c < NCH; c++) begin
            m_ben[c] = 0; m_addr[c] = 0; m_wbase[c] = 0; m_wr[c] = 0; m_unc[c] = 0;
            m_beats[c] = 0; m_err[c] = 0;
        end
        clr_model();

        // reset state, with a request present
        ch_ben = {NCH{4'hf}};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valids", {arvalid, awvalid, wvalid, wlast, rready, bready}, 6'd0);
        chk("rst_pulses", {ch_addr_ok, ch_beat_ok, ch_data_ok, ch_err}, '0);
        ch_ben = '0;
        @(negedge clk); rst = 0;

        // uncached single accesses from the table
        for (int i = 0; i < 7; i++) begin
            req(0, tbl[i].wr, 1, tbl[i].ben, tbl[i].addr);
            drain(100);
            chk("tbl_addr", cap_addr, tbl[i].eaddr);
            chk("tbl_size", cap_size, tbl[i].esize);
            chk("tbl_len", cap_len, 8'd0);
            chk("tbl_beats", cap_beats, 1);
            if (tbl[i].wr) chk("tbl_strb", cap_strb, tbl[i].estrb);
        end

        // cached read line fill
        req(1, 0, 0, 4'hf, 32'h0000_1234);
        drain(100);
`ifdef BRIDGE_WRAP_EN
        chk("line_addr", cap_addr, 32'h0000_1234);
        chk("line_burst", cap_burst, 2'b10);
`else
        chk("line_addr", cap_addr, 32'h0000_1220);
        chk("line_burst", cap_burst, 2'b01);
`endif
        chk("line_len", cap_len, 8'd7);
        chk("line_beats", cap_beats, 8);

        // both channels requesting continuously -> alternate grants
        glog.delete();
        m_auto[0] = 1; m_auto[1] = 1;
        req(0, 0, 1, 4'hf, 32'h10); req(1, 0, 1, 4'hf, 32'h20);
        for (int n = 0; n < 100 && glog.size() < 5; n++) step();
        m_auto[0] = 0; m_auto[1] = 0;
        drain(100);
        chk("rr_count", glog.size() >= 5, 1);
        for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);

        // SLVERR on beat 3 of 8, then a clean transaction
        force_err = 2;
        req(0, 0, 0, 4'hf, 32'h0000_4000);
        drain(100);
        chk("err_set", cap_err, 1);
        chk("err_beats", cap_beats, 8);
        force_err = -1;
        req(0, 0, 1, 4'hf, 32'h0000_4004);
        drain(100);
        chk("err_clear", cap_err, 0);

        // reset during W beat 4 of a cached write
        req(0, 1, 0, 4'hf, 32'h0000_0820);
        for (int n = 0; n < 100 && !(w_act && w_beat == 4); n++) step();
        chk("reach_beat4", w_beat, 4);
        @(negedge clk); rst = 1; #1;
        chk("midrst_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, 6'd0);
        chk("midrst_pulses", {ch_beat_ok, ch_data_ok}, '0);
        clr_model();
        @(negedge clk); rst = 0;
        begin
            int naw0;
            naw0 = n_aw;
            req(1, 1, 0, 4'hf, 32'h0000_0900);
            drain(100);
            chk("fresh_aw", n_aw, naw0 + 1);
            chk("fresh_addr", cap_addr, 32'h0000_0900);
            chk("fresh_beats", cap_beats, 8);
        end

        // randomized traffic with slave waits, errors and dropped requests
        rnd = 1;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!m_act[c] && cur != c && $urandom_range(0, 7) == 0)
                    req(c, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        blist[$urandom_range(0, 6)], $urandom);
                else if (m_act[c] && $urandom_range(0, 40) == 0)
                    m_act[c] = 0;
            end
            step();
        end
        drain(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
